snax_gemm_tcdm_rd_ctrl: RTL

// - Read-side sequencer between the GEMM core and its TCDM input ports: takes one read command (A/B base addr),

---
 rtl/snax_gemm_tcdm_rd_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/snax_gemm_tcdm_rd_ctrl.sv
// snax_gemm_tcdm_rd_ctrl
// Read-side sequencer between the GEMM core and its TCDM input ports. One
// command fetches NumPorts words (lower half = A operand, upper half = B),
// tracks per-port grants and out-of-order responses, and presents the operand
// vector only once every port has returned data.
//
// Optional feature: define SNAX_GEMM_RD_PERF_EN to build the stall-cycle
// counter on perf_stall_o; otherwise perf_stall_o is tied to zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready_o high, no TCDM traffic
// REQ   | issuing requests on every not-yet-granted port
// RSP   | all ports granted, collecting the remaining responses
// OUT   | operand vector valid, waiting for the GEMM to consume it
//
// NumPorts must be even and at least 2.

module snax_gemm_tcdm_rd_ctrl #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned NumPorts   = 16,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned WordStride = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic [AddrWidth-1:0]                cmd_addr_a_i,
  input  logic [AddrWidth-1:0]                cmd_addr_b_i,
  output logic [NumPorts-1:0]                 tcdm_q_valid_o,
  output logic [NumPorts*AddrWidth-1:0]       tcdm_q_addr_o,
  input  logic [NumPorts-1:0]                 tcdm_q_ready_i,
  input  logic [NumPorts-1:0]                 tcdm_p_valid_i,
  input  logic [NumPorts*DataWidth-1:0]       tcdm_p_data_i,
  output logic                                data_valid_o,
  input  logic                                data_ready_i,
  output logic [NumPorts/2*DataWidth-1:0]     data_a_o,
  output logic [NumPorts/2*DataWidth-1:0]     data_b_o,
  output logic                                busy_o,
  output logic [31:0]                         perf_stall_o
);

  localparam int unsigned HalfPorts = NumPorts / 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StRsp  = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic [NumPorts-1:0]           granted_q, granted_d;
  logic [NumPorts-1:0]           received_q, received_d;
  logic [AddrWidth-1:0]          base_a_q, base_a_d;
  logic [AddrWidth-1:0]          base_b_q, base_b_d;
  logic [NumPorts*DataWidth-1:0] data_q, data_d;

  logic [NumPorts-1:0]           q_valid;
  logic [NumPorts*AddrWidth-1:0] q_addr;
  logic [NumPorts-1:0]           grant_fire;
  logic [NumPorts-1:0]           rsp_fire;
  logic                          collecting;

  assign collecting = (state_q == StReq) || (state_q == StRsp);

  // Request generation: every ungranted port requests while in REQ. The
  // address is a pure function of the latched bases, so it stays stable until
  // the port is granted. Addresses are zeroed outside REQ to keep the bus quiet.
  always_comb begin
    q_valid = '0;
    q_addr  = '0;
    if (state_q == StReq) begin
      q_valid = ~granted_q;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (i < HalfPorts) begin
          q_addr[i*AddrWidth +: AddrWidth] = base_a_q + AddrWidth'(i * WordStride);
        end else begin
          q_addr[i*AddrWidth +: AddrWidth] = base_b_q + AddrWidth'((i - HalfPorts) * WordStride);
        end
      end
    end
  end

  assign grant_fire = q_valid & tcdm_q_ready_i;

  // A response only counts on a port whose grant was registered in an earlier
  // cycle and which has not delivered yet; anything else is stray traffic.
  assign rsp_fire = collecting ? (tcdm_p_valid_i & granted_q & ~received_q)
                               : {NumPorts{1'b0}};

  // Next-state, mask and data-capture logic.
  always_comb begin
    state_d    = state_q;
    granted_d  = granted_q;
    received_d = received_q | rsp_fire;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    data_d     = data_q;

    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (rsp_fire[i]) begin
        data_d[i*DataWidth +: DataWidth] = tcdm_p_data_i[i*DataWidth +: DataWidth];
      end
    end

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          base_a_d   = cmd_addr_a_i;
          base_b_d   = cmd_addr_b_i;
          granted_d  = '0;
          received_d = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        granted_d = granted_q | grant_fire;
        if (&granted_d) begin
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (&received_d) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (data_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, masks, bases and operand registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      granted_q  <= '0;
      received_q <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      granted_q  <= granted_d;
      received_q <= received_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      data_q     <= data_d;
    end
  end

  assign tcdm_q_valid_o = q_valid;
  assign tcdm_q_addr_o  = q_addr;
  assign cmd_ready_o    = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign data_valid_o   = (state_q == StOut);
  assign data_a_o       = data_q[HalfPorts*DataWidth-1:0];
  assign data_b_o       = data_q[NumPorts*DataWidth-1:HalfPorts*DataWidth];

`ifdef SNAX_GEMM_RD_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall;

  // Stall cycle: a request is waiting for its grant, or a granted port is
  // still waiting for its response. Saturating count, cleared only by reset.
  always_comb begin
    stall  = (|(q_valid & ~tcdm_q_ready_i)) |
             (|(granted_q & ~received_q & ~tcdm_p_valid_i));
    perf_d = perf_q;
    if (collecting && stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule
